display_scan: RTL and testbench



---
 rtl/display_pkg.sv | 29 ++
 rtl/display_if.sv | 12 +
 rtl/seg7_decode.sv | 26 ++
 rtl/display_scan.sv | 139 +++++++++++++
 tb/tb_display_scan.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for seven-segment display stages: glyphs and slot encodings.
package display_pkg;

  // Scan slot of the 4-digit display; S_IDLE is the permanently dark position.
  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_TENS  = 2'd1,
    S_HUND  = 2'd2,
    S_IDLE  = 2'd3
  } slot_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Active-low digit enables with every digit dark.
  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/display_if.sv
// Display bus: BCD word in from the converter, scanned digit drive out.
interface display_if;
  logic [9:0] bcd;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  modport master (output bcd, blank_lz, input an, seg, dp, frame);
  modport slave  (input bcd, blank_lz, output an, seg, dp, frame);
endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment glyph; 10..15 show a dash.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Standard digit glyphs, anything out of decimal range becomes a dash.
  always_comb begin
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit time-multiplexed seven-segment scanner with a per-frame snapshot of
// the BCD word, optional leading-zero blanking and a permanently dark fourth digit.
module display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic      clk,
  input  logic      rst_n,
  display_if.slave  bus
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count;
  logic             tick;
  logic             tick_d;
  logic             load;
  slot_t            idx;
  slot_t            idx_next;
  logic [9:0]       snap_bcd;
  logic             snap_lz;
  logic [3:0]       digit;
  logic [6:0]       glyph;
  logic             hund_zero;
  logic             tens_zero;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic [3:0]       an_reg;
  logic [6:0]       seg_reg;

  assign tick = (count == CNT_LAST);
  // The snapshot loads on the tick that wraps the idle slot back to units.
  assign load = tick && (idx == S_IDLE);

  // Prescaler: one tick every REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

  // Slot state register plus a delayed tick so outputs follow the slot by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= S_UNITS;
      tick_d <= 1'b0;
    end else begin
      idx    <= idx_next;
      tick_d <= tick;
    end
  end

  // Next slot: step through units, tens, hundreds, idle on every tick.
  always_comb begin
    idx_next = idx;
    if (tick) begin
      case (idx)
        S_UNITS: idx_next = S_TENS;
        S_TENS:  idx_next = S_HUND;
        S_HUND:  idx_next = S_IDLE;
        default: idx_next = S_UNITS;
      endcase
    end
  end

  // Frame snapshot so a digit update never tears across slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bcd <= '0;
      snap_lz  <= 1'b0;
    end else if (load) begin
      snap_bcd <= bus.bcd;
      snap_lz  <= bus.blank_lz;
    end
  end

  // Digit select for the shared decoder; hundreds value 3 is forced to a dash code.
  always_comb begin
    digit = snap_bcd[3:0];
    case (idx)
      S_TENS:  digit = snap_bcd[7:4];
      S_HUND:  digit = (snap_bcd[9:8] == 2'd3) ? 4'hF : {2'b00, snap_bcd[9:8]};
      default: digit = snap_bcd[3:0];
    endcase
  end

  seg7_decode u_decode (
    .value (digit),
    .seg   (glyph)
  );

  // Dash digits are nonzero, so they never trigger blanking of themselves or lower digits.
  assign hund_zero = (snap_bcd[9:8] == 2'd0);
  assign tens_zero = (snap_bcd[7:4] == 4'd0);

  // Output decode per slot, including leading-zero blanking.
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    case (idx)
      S_UNITS: begin
        an_next  = 4'b1110;
        seg_next = glyph;
      end
      S_TENS: begin
        if (!(snap_lz && hund_zero && tens_zero)) begin
          an_next  = 4'b1101;
          seg_next = glyph;
        end
      end
      S_HUND: begin
        if (!(snap_lz && hund_zero)) begin
          an_next  = 4'b1011;
          seg_next = glyph;
        end
      end
      default: ;
    endcase
  end

  // Enables and segments load together, one cycle after the slot advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG_OFF;
    end else if (tick_d) begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign bus.an    = an_reg;
  assign bus.seg   = seg_reg;
  assign bus.dp    = 1'b1;
  assign bus.frame = load;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan with REFRESH_DIV=4: stimulus pushes the
// expected four-slot frame, a monitor pops it on each frame pulse and checks it.
module tb_display_scan;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GX = 7'b1111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_exp_t;
  typedef slot_exp_t [3:0] frame_exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic mon_busy;
  frame_exp_t exp_q[$];

  display_if bus_if ();

  display_scan #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0] a0, input logic [6:0] s0,
                            input logic [3:0] a1, input logic [6:0] s1,
                            input logic [3:0] a2, input logic [6:0] s2);
    frame_exp_t f;
    f[0] = {a0, s0};
    f[1] = {a1, s1};
    f[2] = {a2, s2};
    f[3] = {4'hF, GX};
    exp_q.push_back(f);
  endtask

  task automatic drive(input logic [9:0] v, input logic lz);
    bus_if.bcd      = v;
    bus_if.blank_lz = lz;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Counts rising edges after release until the first digit enable change.
  task automatic check_restart(input string tag);
    int n;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus_if.an !== 4'hF) break;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_an"}, bus_if.an, 4'b1101);
    check({tag, "_seg"}, bus_if.seg, G0);
  endtask

  // Monitor: on each frame pulse with a pending expectation, check all four slots.
  initial begin
    frame_exp_t cur;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.frame === 1'b1 && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        mon_busy = 1'b1;
        for (int k = 1; k <= 15; k++) begin
          @(negedge clk);
          if (k == 1) check("frame_width", bus_if.frame, 1'b0);
          for (int s = 0; s < 3; s++) begin
            if (k == 4 * s + 2 || k == 4 * s + 5)
              check($sformatf("slot%0d_k%0d", s, k), {bus_if.an, bus_if.seg}, cur[s]);
          end
          if (k == 14 || k == 15)
            check($sformatf("idle_k%0d", k), {bus_if.an, bus_if.seg}, cur[3]);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(10'd0, 1'b0);

    // Reset holds everything dark regardless of bcd activity.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(10'(i * 37 + 5), i[0]);
      check($sformatf("rst_an_%0d", i), bus_if.an, 4'hF);
      check($sformatf("rst_seg_%0d", i), bus_if.seg, GX);
      check($sformatf("rst_dp_%0d", i), bus_if.dp, 1'b1);
      check($sformatf("rst_frame_%0d", i), bus_if.frame, 1'b0);
    end
    drive(10'd0, 1'b0);
    rst_n = 1'b1;
    check_restart("release");

    // Full-scale 255, no blanking, two consecutive frames.
    wait_idle();
    drive(10'b10_0101_0101, 1'b0);
    push_frame(4'b1110, G5, 4'b1101, G5, 4'b1011, G2);
    push_frame(4'b1110, G5, 4'b1101, G5, 4'b1011, G2);

    // Leading-zero blanking cases.
    wait_idle();
    drive(10'b00_0000_0111, 1'b1);
    push_frame(4'b1110, G7, 4'hF, GX, 4'hF, GX);
    wait_idle();
    drive(10'd0, 1'b1);
    push_frame(4'b1110, G0, 4'hF, GX, 4'hF, GX);
    wait_idle();
    drive(10'b00_0101_0000, 1'b1);
    push_frame(4'b1110, G0, 4'b1101, G5, 4'hF, GX);
    wait_idle();
    drive(10'b01_0000_0011, 1'b1);
    push_frame(4'b1110, G3, 4'b1101, G0, 4'b1011, G1);

    // Tear-free capture: 123 then 200 injected mid-frame.
    wait_idle();
    drive(10'b01_0010_0011, 1'b0);
    push_frame(4'b1110, G3, 4'b1101, G2, 4'b1011, G1);
    n = 0;
    while (!mon_busy && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) check("tear_wait_timeout", 32'd1, 32'd0);
    repeat (6) @(posedge clk);
    #2;
    drive(10'b10_0000_0000, 1'b0);
    push_frame(4'b1110, G0, 4'b1101, G0, 4'b1011, G2);

    // Illegal digits show dashes, with and without blanking.
    wait_idle();
    drive(10'b11_1010_1111, 1'b0);
    push_frame(4'b1110, GD, 4'b1101, GD, 4'b1011, GD);
    wait_idle();
    drive(10'b11_1010_1111, 1'b1);
    push_frame(4'b1110, GD, 4'b1101, GD, 4'b1011, GD);
    wait_idle();
    drive(10'b00_1100_0001, 1'b1);
    push_frame(4'b1110, G1, 4'b1101, GD, 4'hF, GX);

    // Asynchronous reset during the hundreds slot.
    wait_idle();
    drive(10'b10_0101_0101, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.frame !== 1'b1 && n < 100);
    if (n >= 100) check("midrst_frame_timeout", 32'd1, 32'd0);
    repeat (10) @(negedge clk);
    check("midrst_pre_an", bus_if.an, 4'b1011);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_async_an", bus_if.an, 4'hF);
    check("midrst_async_seg", bus_if.seg, GX);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_restart("midrst");

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
